// File: rtl/full_adder.sv
// Purpose: ripple-carry adder built from WIDTH identical full-adder cells; {C,S} = Ain + Bin + Cin.
// Latency: 1 cycle with REG_OUT=1 (registered outputs), 0 cycles with REG_OUT=0 (pure combinational).
// Backpressure: none; a new operand set is accepted every cycle when in_valid is high.
//
// Ports:
//    clk       rising-edge clock (unused when REG_OUT=0)
//    rst       asynchronous active-high reset, clears S/C/out_valid (unused when REG_OUT=0)
//    Ain, Bin  WIDTH-bit unsigned operands
//    Cin       carry into bit 0
//    in_valid  qualifies Ain/Bin/Cin
//    S         low WIDTH bits of the sum
//    C         carry out of the MSB
//    out_valid qualifies S/C
module full_adder #(
   parameter int WIDTH   = 1,
   parameter bit REG_OUT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Ain,
   input  logic [WIDTH-1:0] Bin,
   input  logic             Cin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] S,
   output logic             C,
   output logic             out_valid
);

   // carry[i] is the carry into cell i; carry[WIDTH] is the final carry-out.
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;

   assign carry[0] = Cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign sum[i]     = Ain[i] ^ Bin[i] ^ carry[i];
      assign carry[i+1] = (Ain[i] & Bin[i]) | (Ain[i] & carry[i]) | (Bin[i] & carry[i]);
   end

   if (REG_OUT) begin : g_reg
      // Results are only refreshed on valid cycles; otherwise the last result is held
      // and out_valid drops so downstream sees a one-cycle-wide valid per result.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            S         <= '0;
            C         <= 1'b0;
            out_valid <= 1'b0;
         end else if (in_valid) begin
            S         <= sum;
            C         <= carry[WIDTH];
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end else begin : g_comb
      // Clock and reset have no role in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign S         = sum;
      assign C         = carry[WIDTH];
      assign out_valid = in_valid;
   end

endmodule

// File: tb/tb_full_adder.sv
// Purpose: scoreboard bench for full_adder in three builds (1-bit registered, 4-bit registered, 1-bit combinational).
// Latency: expects registered results one edge after capture, combinational results immediately.
// Backpressure: none exercised; the DUT accepts every cycle.
module tb_full_adder;

   typedef struct {
      logic       s1;
      logic       c1;
      logic [3:0] s4;
      logic       c4;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       a1 = 1'b0, b1 = 1'b0, cin = 1'b0, vld = 1'b0;
   logic [3:0] a4 = 4'h0, b4 = 4'h0;

   logic       s1, c1, ov1;
   logic [3:0] s4;
   logic       c4, ov4;
   logic       sc, cc, ovc;

   int tests = 0;
   int fails = 0;

   exp_t exp_q[$];
   exp_t held;

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1), .REG_OUT(1)) dut1 (
      .clk(clk), .rst(rst), .Ain(a1), .Bin(b1), .Cin(cin), .in_valid(vld),
      .S(s1), .C(c1), .out_valid(ov1));

   full_adder #(.WIDTH(4), .REG_OUT(1)) dut4 (
      .clk(clk), .rst(rst), .Ain(a4), .Bin(b4), .Cin(cin), .in_valid(vld),
      .S(s4), .C(c4), .out_valid(ov4));

   full_adder #(.WIDTH(1), .REG_OUT(0)) dutc (
      .clk(clk), .rst(rst), .Ain(a1), .Bin(b1), .Cin(cin), .in_valid(vld),
      .S(sc), .C(cc), .out_valid(ovc));

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: plain unsigned addition at full width.
   function automatic exp_t model(input logic a, input logic b, input logic [3:0] wa,
                                  input logic [3:0] wb, input logic ci);
      exp_t e;
      logic [1:0] r1;
      logic [4:0] r4;
      r1 = {1'b0, a} + {1'b0, b} + {1'b0, ci};
      r4 = {1'b0, wa} + {1'b0, wb} + {4'b0, ci};
      e.s1 = r1[0];
      e.c1 = r1[1];
      e.s4 = r4[3:0];
      e.c4 = r4[4];
      return e;
   endfunction

   // Drive one cycle of stimulus, push the expected registered result, check the combinational build.
   task automatic drive(input logic a, input logic b, input logic [3:0] wa,
                        input logic [3:0] wb, input logic ci, input logic v);
      exp_t e;
      @(negedge clk);
      a1 = a; b1 = b; a4 = wa; b4 = wb; cin = ci; vld = v;
      e = model(a, b, wa, wb, ci);
      if (v) exp_q.push_back(e);
      #1;
      check("comb_S", {7'b0, sc}, {7'b0, e.s1});
      check("comb_C", {7'b0, cc}, {7'b0, e.c1});
      check("comb_valid", {7'b0, ovc}, {7'b0, v});
   endtask

   // Monitor: sample just after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            check("rst_S1", {7'b0, s1}, 8'h0);
            check("rst_C1", {7'b0, c1}, 8'h0);
            check("rst_valid1", {7'b0, ov1}, 8'h0);
            check("rst_S4", {4'b0, s4}, 8'h0);
            check("rst_valid4", {7'b0, ov4}, 8'h0);
         end else if (ov1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 8'h1, 8'h0);
            end else begin
               e = exp_q.pop_front();
               held = e;
               check("S1", {7'b0, s1}, {7'b0, e.s1});
               check("C1", {7'b0, c1}, {7'b0, e.c1});
               check("valid4", {7'b0, ov4}, 8'h1);
               check("S4", {4'b0, s4}, {4'b0, e.s4});
               check("C4", {7'b0, c4}, {7'b0, e.c4});
            end
         end else begin
            check("missing_valid", {7'b0, exp_q.size() != 0}, 8'h0);
            check("valid4_idle", {7'b0, ov4}, 8'h0);
            check("hold_S1", {7'b0, s1}, {7'b0, held.s1});
            check("hold_C1", {7'b0, c1}, {7'b0, held.c1});
            check("hold_S4", {4'b0, s4}, {4'b0, held.s4});
            check("hold_C4", {7'b0, c4}, {7'b0, held.c4});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      held = '{s1: 1'b0, c1: 1'b0, s4: 4'h0, c4: 1'b0};

      // Reset with all inputs high: outputs must clear before any clock edge.
      a1 = 1'b1; b1 = 1'b1; cin = 1'b1; vld = 1'b1; a4 = 4'hF; b4 = 4'hF;
      #2 rst = 1'b1;
      #1;
      check("async_rst_S1", {7'b0, s1}, 8'h0);
      check("async_rst_C1", {7'b0, c1}, 8'h0);
      check("async_rst_valid1", {7'b0, ov1}, 8'h0);
      check("async_rst_S4", {4'b0, s4}, 8'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; vld = 1'b0;

      // Truth-table walk.
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 4'h2, 4'h5, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 4'h9, 4'h6, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1);

      // Hold: inputs change but in_valid is low.
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

      // Mid-stream reset pulse between edges.
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_S1", {7'b0, s1}, 8'h0);
      check("mid_rst_C1", {7'b0, c1}, 8'h0);
      check("mid_rst_valid1", {7'b0, ov1}, 8'h0);
      check("mid_rst_C4", {7'b0, c4}, 8'h0);
      held = '{s1: 1'b0, c1: 1'b0, s4: 4'h0, c4: 1'b0};
      #1 rst = 1'b0;
      drive(1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 1'b1);

      // 4-bit boundary vectors.
      drive(1'b1, 1'b1, 4'hF, 4'h1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 4'h7, 4'h8, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 4'h3, 4'h4, 1'b1, 1'b1);

      // All eight 1-bit combinations.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = i[2:0];
         drive(v[2], v[1], {1'b0, v}, {v, 1'b1}, v[0], 1'b1);
      end

      // Randomized traffic with gaps.
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      end

      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      check("queue_drained", 8'(exp_q.size()), 8'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/full_adder.md
# full_adder

Registered one-bit full adder with an optional ripple-carry vector extension. It sums `Ain`, `Bin` and carry-in `Cin` and presents the sum `S` and carry-out `C`. It is the leaf arithmetic cell of the adder library and is instantiated directly, or chained, by wider datapath adders.

## Interface
Parameters:
- `WIDTH`, default 1: operand width in bits; `WIDTH=1` is the classic full adder.
- `REG_OUT`, default 1: 1 registers the outputs (1-cycle latency); 0 makes them purely combinational.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `Ain`  in  WIDTH  operand A.
- `Bin`  in  WIDTH  operand B.
- `Cin`  in  1  carry-in into bit 0.
- `in_valid`  in  1  qualifies `Ain`/`Bin`/`Cin` this cycle.
- `S`  out  WIDTH  sum bits.
- `C`  out  1  carry-out of the MSB.
- `out_valid`  out  1  qualifies `S`/`C`.

## Operation
- Bit cell i: `s[i] = a[i] ^ b[i] ^ c[i]`; `c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])`; `c[0] = Cin`.
- Implement as a generate chain of WIDTH identical 1-bit cells (ripple carry).
- `S = c-chain sums[WIDTH-1:0]`, `C = c[WIDTH]`; equivalently `{C,S} = Ain + Bin + Cin` computed at WIDTH+1 bits, unsigned, with no truncation of the carry.
- Overflow wraps: `S` holds the low WIDTH bits only, and `C` carries the excess.
- `REG_OUT=1`:
  - On a rising edge with `in_valid=1`, register `S` and `C` from the current inputs and set `out_valid=1`.
  - On a rising edge with `in_valid=0`, hold `S` and `C` and set `out_valid=0`.
- `REG_OUT=0`:
  - `S` and `C` follow the inputs combinationally regardless of `in_valid`.
  - `out_valid = in_valid`.
  - `clk` and `rst` are unused.
- No internal state besides the output registers. No back-pressure: the block accepts an input every cycle.
- X on any input propagates to the outputs; no X-masking is required.

## Timing
- Reset (`REG_OUT=1`): `rst` high forces `S=0`, `C=0`, `out_valid=0` immediately, without waiting for a clock edge.
- Reset release: the first capture is the first rising edge with `rst` low.
- Reset asserted mid-stream: the in-flight result is discarded, outputs read 0, and `out_valid` is 0.
- Latency: 1 cycle when `REG_OUT=1`, 0 cycles when `REG_OUT=0`.
- Throughput: 1 result per cycle.
- Inputs changing between edges have no effect on the registered outputs until the next rising edge.
- The combinational path is the WIDTH-deep carry chain and must close timing at the target clock for `WIDTH≤16`.

## Test plan
- Reset: assert `rst` with `Ain=Bin=Cin=1`, `in_valid=1` -> `S=0`, `C=0`, `out_valid=0` at once and held while `rst` is high.
- Truth-table walk (`WIDTH=1`), one vector per cycle with `in_valid=1`: (0,0,0)->S=0,C=0; (0,0,1)->S=1,C=0; (0,1,1)->S=0,C=1; (1,0,1)->S=0,C=1; (1,1,1)->S=1,C=1, each visible one cycle later with `out_valid=1`.
- Hold: `in_valid=0` after (1,1,1) while the inputs change to (0,0,0) -> `S=1`, `C=1` held and `out_valid=0`.
- Mid-stream reset: pulse `rst` between edges while the output shows S=1,C=1 -> the output clears to 0 asynchronously; the next valid vector (1,0,0) gives S=1,C=0.
- Vector, `WIDTH=4`: Ain=4'hF, Bin=4'h1, Cin=0 -> S=4'h0, C=1; Ain=4'h7, Bin=4'h8, Cin=1 -> S=4'h0, C=1; Ain=4'h3, Bin=4'h4, Cin=1 -> S=4'h8, C=0.
- Combinational mode (`REG_OUT=0`): apply all 8 combinations of `Ain`/`Bin`/`Cin` for `WIDTH=1` -> `{C,S}` equals `Ain+Bin+Cin` in the same delta cycle, and `out_valid` tracks `in_valid`.
